// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port, synchronous-read framebuffer RAM between the display
// fetch path and CPU register-interface accesses. Display fetches always win;
// the CPU fills the remaining slots. Each access takes three cycles:
// grant (IDLE) -> ISSUE (ram_en high) -> CAPTURE (ram_rdata valid).
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   x_pos, y_pos      current character cell from the timing generator
//   blank             1 = outside the active area
//   cpu_req/we/addr/wdata  CPU request, held until cpu_ready
//   cpu_ready         one-cycle completion pulse
//   cpu_rdata         read data, valid with cpu_ready and held afterwards
//   ram_en/we/addr/wdata   registered RAM controls
//   ram_rdata         RAM read data, valid the cycle after ram_en
//   pixel_out         registered colour of the current cell, 0 during blank
//   underrun          sticky: a display fetch was overtaken by a newer cell
//   underrun_clr      clears underrun (wins over a same-cycle underrun)
//
// state   | meaning
// IDLE    | arbitrate: pending display fetch first, then CPU
// ISSUE   | ram_en high for one cycle
// CAPTURE | ram_rdata valid; route it to pixel_out or cpu_rdata
module vga_fb_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        x_pos,
  input  logic [3:0]        y_pos,
  input  logic              blank,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pixel_out,
  output logic              underrun,
  input  logic              underrun_clr
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [ADDR_W-1:0] pend_addr;
  logic              disp_pending;
  logic              blank_d;
  logic              owner_disp;
  logic              owner_we;
  logic              disp_set;

  assign cur_addr = ADDR_W'({y_pos, x_pos});

  // A new cell in the active area, or the first active cycle after blanking.
  assign disp_set = !blank && ((cur_addr != last_addr) || blank_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_addr    <= '0;
      pend_addr    <= '0;
      disp_pending <= 1'b0;
      blank_d      <= 1'b0;
      owner_disp   <= 1'b0;
      owner_we     <= 1'b0;
      cpu_ready    <= 1'b0;
      cpu_rdata    <= '0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      pixel_out    <= '0;
      underrun     <= 1'b0;
    end else begin
      last_addr <= cur_addr;
      blank_d   <= blank;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      cpu_ready <= 1'b0;

      if (underrun_clr)
        underrun <= 1'b0;
      else if (disp_set && disp_pending)
        underrun <= 1'b1;

      if (disp_set) begin
        disp_pending <= 1'b1;
        pend_addr    <= cur_addr;
      end

      if (blank)
        pixel_out <= '0;

      case (state)
        IDLE: begin
          // A set arriving this cycle is granted immediately with the newest
          // address, so an older pending cell is simply superseded.
          if (disp_pending || disp_set) begin
            disp_pending <= 1'b0;
            owner_disp   <= 1'b1;
            owner_we     <= 1'b0;
            ram_en       <= 1'b1;
            ram_addr     <= disp_set ? cur_addr : pend_addr;
            state        <= ISSUE;
          end else if (cpu_req && !cpu_ready) begin
            // cpu_ready high means the held request was just serviced.
            owner_disp <= 1'b0;
            owner_we   <= cpu_we;
            ram_en     <= 1'b1;
            ram_we     <= cpu_we;
            ram_addr   <= cpu_addr;
            if (cpu_we)
              ram_wdata <= cpu_wdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (owner_disp) begin
            if (!blank)
              pixel_out <= ram_rdata;
          end else begin
            if (!owner_we)
              cpu_rdata <= ram_rdata;
            cpu_ready <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
